// File: rtl/pi_mc_pkg.sv
// Shared types and width helpers for the multi-axis PI controller.
// The FSM enum, the default gain fraction width and the datapath width derivations live here.
package pi_mc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    PMUL,
    IMUL,
    OUT,
    DONE
  } state_t;

  localparam int FRAC_DEFAULT = 8;

  // Width of one gain*value product.
  // Two such products can be summed without overflow.
  function automatic int prod_width(input int gain_w, input int data_w);
    return gain_w + data_w + 2;
  endfunction

  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/pi_mc_saturate.sv
// Signed clamp of a wide value into [MIN_V, MAX_V], narrowed to OUT_W bits.
// Used by the error, integrator and output stages of the PI controller.
module pi_mc_saturate #(
  parameter int                     IN_W  = 33,
  parameter int                     OUT_W = 32,
  parameter logic signed [IN_W-1:0] MAX_V = '0,
  parameter logic signed [IN_W-1:0] MIN_V = '0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  always_comb begin
    if (din > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
    end else begin
      dout = din[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pi_multi_axis_controller.sv
// Time-multiplexed PI speed controller for NCH axes.
// One shared multiplier is used; each channel takes a 4-cycle slot: ERR, PMUL, IMUL, OUT.
module pi_multi_axis_controller
  import pi_mc_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DATA_W    = 32,
  parameter int GAIN_W    = 16,
  parameter int FRAC      = FRAC_DEFAULT,
  parameter int OUT_W     = 16,
  parameter int CMD_MAX   = 10000,
  parameter int INT_LIMIT = 2**30
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_en,
  input  logic [NCH-1:0]          ch_enable,
  input  logic [NCH*DATA_W-1:0]   desired_speed,
  input  logic [NCH*DATA_W-1:0]   actual_speed,
  input  logic [NCH*GAIN_W-1:0]   kp_vec,
  input  logic [NCH*GAIN_W-1:0]   ki_vec,
  output logic [NCH*OUT_W-1:0]    control_out,
  output logic [NCH-1:0]          sat_hi,
  output logic [NCH-1:0]          sat_lo,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int PW = prod_width(GAIN_W, DATA_W);
  localparam int CW = ch_width(NCH);
  localparam int EW = DATA_W + 1;

  localparam logic signed [EW-1:0] ERR_MAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [EW-1:0] ERR_MIN = {2'b11, {(DATA_W-1){1'b0}}};
  localparam logic signed [EW-1:0] INT_MAX = EW'(INT_LIMIT);
  localparam logic signed [EW-1:0] INT_MIN = -EW'(INT_LIMIT);
  localparam logic signed [PW-1:0] CMD_HI  = PW'(CMD_MAX);
  localparam logic signed [PW-1:0] CMD_LO  = -PW'(CMD_MAX);

  state_t state, state_nxt;
  logic [CW-1:0] ch;
  logic          last_ch;

  logic signed [DATA_W-1:0] sp_q    [NCH];
  logic signed [DATA_W-1:0] fb_q    [NCH];
  logic signed [DATA_W-1:0] integ_q [NCH];
  logic [GAIN_W-1:0]        kp_q    [NCH];
  logic [GAIN_W-1:0]        ki_q    [NCH];
  logic signed [OUT_W-1:0]  cmd_q   [NCH];
  logic [NCH-1:0]           en_q;
  logic signed [DATA_W-1:0] err_q;
  logic signed [PW-1:0]     acc_q;

  logic signed [EW-1:0]     diff, int_sum;
  logic signed [DATA_W-1:0] err_sat, int_sat;
  logic [GAIN_W-1:0]        mul_a;
  logic signed [DATA_W-1:0] mul_b;
  logic signed [PW-1:0]     mul_p, u;
  logic signed [OUT_W-1:0]  u_sat;
  logic                     hold;

  assign last_ch = (ch == CW'(NCH - 1));

  assign diff    = {sp_q[ch][DATA_W-1], sp_q[ch]} - {fb_q[ch][DATA_W-1], fb_q[ch]};
  assign int_sum = {integ_q[ch][DATA_W-1], integ_q[ch]} + {err_q[DATA_W-1], err_q};

  // Anti-windup: stop integrating further into a saturated output.
  assign hold = (sat_hi[ch] && !err_q[DATA_W-1] && (err_q != '0)) ||
                (sat_lo[ch] && err_q[DATA_W-1]);

  assign mul_a = (state == IMUL) ? ki_q[ch] : kp_q[ch];
  assign mul_b = (state == IMUL) ? integ_q[ch] : err_q;
  assign mul_p = $signed({{(PW-GAIN_W){1'b0}}, mul_a}) *
                 $signed({{(PW-DATA_W){mul_b[DATA_W-1]}}, mul_b});

  assign u = acc_q >>> FRAC;

  pi_mc_saturate #(.IN_W(EW), .OUT_W(DATA_W), .MAX_V(ERR_MAX), .MIN_V(ERR_MIN))
    u_err_sat (.din(diff), .dout(err_sat));

  pi_mc_saturate #(.IN_W(EW), .OUT_W(DATA_W), .MAX_V(INT_MAX), .MIN_V(INT_MIN))
    u_int_sat (.din(int_sum), .dout(int_sat));

  pi_mc_saturate #(.IN_W(PW), .OUT_W(OUT_W), .MAX_V(CMD_HI), .MIN_V(CMD_LO))
    u_out_sat (.din(u), .dout(u_sat));

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign control_out[k*OUT_W +: OUT_W] = cmd_q[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_en) state_nxt = ERR;
      ERR:     state_nxt = PMUL;
      PMUL:    state_nxt = IMUL;
      IMUL:    state_nxt = OUT;
      OUT:     state_nxt = last_ch ? DONE : ERR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Inputs are snapshotted at the start strobe so the whole sweep sees one consistent sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch      <= '0;
      en_q    <= '0;
      err_q   <= '0;
      acc_q   <= '0;
      sat_hi  <= '0;
      sat_lo  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        sp_q[k]    <= '0;
        fb_q[k]    <= '0;
        integ_q[k] <= '0;
        kp_q[k]    <= '0;
        ki_q[k]    <= '0;
        cmd_q[k]   <= '0;
      end
    end else begin
      done <= (state == DONE);
      if (sample_en && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_en) begin
            ch   <= '0;
            busy <= 1'b1;
            en_q <= ch_enable;
            for (int k = 0; k < NCH; k++) begin
              sp_q[k] <= desired_speed[k*DATA_W +: DATA_W];
              fb_q[k] <= actual_speed[k*DATA_W +: DATA_W];
              kp_q[k] <= kp_vec[k*GAIN_W +: GAIN_W];
              ki_q[k] <= ki_vec[k*GAIN_W +: GAIN_W];
            end
          end
        end
        ERR:  err_q <= err_sat;
        PMUL: begin
          acc_q <= mul_p;
          if (!en_q[ch])  integ_q[ch] <= '0;
          else if (!hold) integ_q[ch] <= int_sat;
        end
        IMUL: acc_q <= acc_q + mul_p;
        OUT: begin
          if (en_q[ch]) begin
            cmd_q[ch]  <= u_sat;
            sat_hi[ch] <= (u > CMD_HI);
            sat_lo[ch] <= (u < CMD_LO);
          end else begin
            cmd_q[ch]  <= '0;
            sat_hi[ch] <= 1'b0;
            sat_lo[ch] <= 1'b0;
          end
          if (!last_ch) ch <= ch + 1'b1;
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_multi_axis_controller.sv
// Self-checking bench for pi_multi_axis_controller with two channels.
// Hand-derived vectors cover the directed cases; random sweeps are compared to an arithmetic model.
module tb_pi_multi_axis_controller;

  localparam int NCH    = 2;
  localparam int DATA_W = 32;
  localparam int GAIN_W = 16;
  localparam int OUT_W  = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  sample_en;
  logic [NCH-1:0]        ch_enable;
  logic [NCH*DATA_W-1:0] desired_speed, actual_speed;
  logic [NCH*GAIN_W-1:0] kp_vec, ki_vec;
  logic [NCH*OUT_W-1:0]  control_out;
  logic [NCH-1:0]        sat_hi, sat_lo;
  logic                  busy, done, overrun;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] en;
    longint     sp0, fb0, sp1, fb1;
    int         kp0, ki0, kp1, ki1;
    int         e0, e1;
    logic [1:0] hi, lo;
  } vec_t;

  vec_t vecs[14];

  longint     m_int[2];
  longint     m_out[2];
  logic [1:0] m_hi, m_lo;

  pi_multi_axis_controller #(
    .NCH(NCH), .DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC(8),
    .OUT_W(OUT_W), .CMD_MAX(10000), .INT_LIMIT(2**30)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .ch_enable(ch_enable),
    .desired_speed(desired_speed), .actual_speed(actual_speed),
    .kp_vec(kp_vec), .ki_vec(ki_vec), .control_out(control_out),
    .sat_hi(sat_hi), .sat_lo(sat_lo), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] en, input longint sp0, input longint fb0,
                              input int kp0, input int ki0, input longint sp1, input longint fb1,
                              input int kp1, input int ki1, input int e0, input int e1,
                              input logic [1:0] hi, input logic [1:0] lo);
    vec_t v;
    v.en = en; v.sp0 = sp0; v.fb0 = fb0; v.kp0 = kp0; v.ki0 = ki0;
    v.sp1 = sp1; v.fb1 = fb1; v.kp1 = kp1; v.ki1 = ki1;
    v.e0 = e0; v.e1 = e1; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input longint e0, input longint e1,
                            input logic [1:0] hi, input logic [1:0] lo);
    checkOutput({tag, " out0"}, longint'($signed(control_out[15:0])), e0);
    checkOutput({tag, " out1"}, longint'($signed(control_out[31:16])), e1);
    checkOutput({tag, " sat_hi"}, longint'(sat_hi), longint'(hi));
    checkOutput({tag, " sat_lo"}, longint'(sat_lo), longint'(lo));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_int[k] = 0;
      m_out[k] = 0;
    end
    m_hi = '0;
    m_lo = '0;
  endtask

  // Controller law written directly in integer arithmetic, one sample for both channels.
  task automatic model_sweep(input vec_t v);
    longint sp[2], fb[2], kp[2], ki[2];
    longint e, acc, q;
    sp[0] = v.sp0; fb[0] = v.fb0; kp[0] = v.kp0; ki[0] = v.ki0;
    sp[1] = v.sp1; fb[1] = v.fb1; kp[1] = v.kp1; ki[1] = v.ki1;
    for (int k = 0; k < 2; k++) begin
      if (!v.en[k]) begin
        m_int[k] = 0; m_out[k] = 0; m_hi[k] = 1'b0; m_lo[k] = 1'b0;
      end else begin
        e = sp[k] - fb[k];
        if (e > 64'sd2147483647)  e = 64'sd2147483647;
        if (e < -64'sd2147483648) e = -64'sd2147483648;
        if (!((m_hi[k] && e > 0) || (m_lo[k] && e < 0))) begin
          m_int[k] = m_int[k] + e;
          if (m_int[k] > 64'sd1073741824)  m_int[k] = 64'sd1073741824;
          if (m_int[k] < -64'sd1073741824) m_int[k] = -64'sd1073741824;
        end
        acc = kp[k] * e + ki[k] * m_int[k];
        q = acc / 256;
        if (acc < 0 && (acc % 256) != 0) q = q - 1;
        m_hi[k] = (q > 10000);
        m_lo[k] = (q < -10000);
        m_out[k] = m_hi[k] ? 10000 : (m_lo[k] ? -10000 : q);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ch_enable     = v.en;
    desired_speed = {v.sp1[31:0], v.sp0[31:0]};
    actual_speed  = {v.fb1[31:0], v.fb0[31:0]};
    kp_vec        = {v.kp1[15:0], v.kp0[15:0]};
    ki_vec        = {v.ki1[15:0], v.ki0[15:0]};
  endtask

  // One full sweep; inputs are scrambled after the strobe and an extra strobe may be injected.
  task automatic run_sweep(input vec_t v, input int inject_at, input string tag);
    int first, pulses;
    applyStimulus(v);
    sample_en = 1'b1;
    @(posedge clk);
    #1 sample_en = 1'b0;
    checkOutput({tag, " busy_start"}, longint'(busy), 1);
    first  = -1;
    pulses = 0;
    for (int c = 1; c <= 14; c++) begin
      desired_speed = {$urandom, $urandom};
      actual_speed  = {$urandom, $urandom};
      kp_vec        = $urandom;
      ki_vec        = $urandom;
      ch_enable     = 2'($urandom_range(0, 3));
      if (c == inject_at) sample_en = 1'b1;
      @(posedge clk);
      #1 sample_en = 1'b0;
      if (done) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    checkOutput({tag, " done_cycle"}, first, 9);
    checkOutput({tag, " done_pulses"}, pulses, 1);
    checkOutput({tag, " busy_end"}, longint'(busy), 0);
    model_sweep(v);
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0; sample_en = 1'b0; ch_enable = '0;
    desired_speed = '0; actual_speed = '0; kp_vec = '0; ki_vec = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 2'b00, 2'b00);
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset done", longint'(done), 0);
    checkOutput("reset overrun", longint'(overrun), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    //             en     sp0          fb0           kp0     ki0 sp1    fb1 kp1     ki1 e0     e1      hi     lo
    vecs[0]  = mk(2'b11, 500,         200,          'h100,  0,  0,     0,  0,      0,  300,   0,      2'b00, 2'b00);
    vecs[1]  = mk(2'b11, 500,         200,          'h100,  0,  2000,  0,  'hA00,  0,  300,   10000,  2'b10, 2'b00);
    vecs[2]  = mk(2'b11, 500,         200,          'h100,  0,  2000,  0,  'hA00,  1,  300,   10000,  2'b10, 2'b00);
    vecs[3]  = mk(2'b11, 500,         200,          'h100,  0,  0,     0,  0,      1,  300,   7,      2'b00, 2'b00);
    vecs[4]  = mk(2'b10, 500,         200,          'h100,  0,  0,     0,  0,      1,  0,     7,      2'b00, 2'b00);
    vecs[5]  = mk(2'b11, 256,         0,            0,      1,  0,     0,  0,      1,  1,     7,      2'b00, 2'b00);
    vecs[6]  = mk(2'b11, 256,         0,            0,      1,  0,     0,  0,      1,  2,     7,      2'b00, 2'b00);
    vecs[7]  = mk(2'b11, 256,         0,            0,      1,  0,     0,  0,      1,  3,     7,      2'b00, 2'b00);
    vecs[8]  = mk(2'b11, 256,         0,            0,      1,  0,     0,  0,      1,  4,     7,      2'b00, 2'b00);
    vecs[9]  = mk(2'b11, 0,           3,            'h80,   0,  -2000, 0,  'hA00,  1,  -2,    -10000, 2'b00, 2'b10);
    vecs[10] = mk(2'b11, 0,           3,            'h80,   0,  -2000, 0,  'hA00,  1,  -2,    -10000, 2'b00, 2'b10);
    vecs[11] = mk(2'b11, 64'sd2147483647, -64'sd2147483648, 1, 0, 0, 0,  0,      0,  10000, 0,      2'b01, 2'b00);
    vecs[12] = mk(2'b11, 0,           0,            0,      1,  0,     0,  0,      0,  10000, 0,      2'b01, 2'b00);
    vecs[13] = mk(2'b11, -64'sd1073741824, 0,       0,      1,  0,     0,  0,      0,  0,     0,      2'b00, 2'b00);

    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_sweep(vecs[i], -1, tag);
      check_outs(tag, vecs[i].e0, vecs[i].e1, vecs[i].hi, vecs[i].lo);
    end

    // A strobe arriving mid-sweep must be dropped and flagged.
    checkOutput("overrun before", longint'(overrun), 0);
    run_sweep(vecs[0], 3, "overrun");
    checkOutput("overrun flag", longint'(overrun), 1);
    check_outs("overrun", m_out[0], m_out[1], m_hi, m_lo);

    // Reset asserted while channel 1 is in its proportional multiply.
    applyStimulus(vecs[1]);
    sample_en = 1'b1;
    @(posedge clk);
    #1 sample_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_outs("midreset", 0, 0, 2'b00, 2'b00);
    checkOutput("midreset busy", longint'(busy), 0);
    checkOutput("midreset done", longint'(done), 0);
    checkOutput("midreset overrun", longint'(overrun), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    run_sweep(vecs[1], -1, "postreset");
    check_outs("postreset", m_out[0], m_out[1], m_hi, m_lo);

    for (int i = 0; i < 20; i++) begin
      string tag;
      tag = $sformatf("rand%0d", i);
      v.en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        v.sp0 = longint'($signed($urandom)); v.fb0 = longint'($signed($urandom));
        v.sp1 = longint'($signed($urandom)); v.fb1 = longint'($signed($urandom));
        v.kp0 = int'($urandom_range(0, 65535)); v.kp1 = int'($urandom_range(0, 65535));
        v.ki0 = int'($urandom_range(0, 65535)); v.ki1 = int'($urandom_range(0, 65535));
      end else begin
        v.sp0 = longint'($urandom_range(0, 20000)) - 10000;
        v.fb0 = longint'($urandom_range(0, 20000)) - 10000;
        v.sp1 = longint'($urandom_range(0, 20000)) - 10000;
        v.fb1 = longint'($urandom_range(0, 20000)) - 10000;
        v.kp0 = int'($urandom_range(0, 1023)); v.kp1 = int'($urandom_range(0, 1023));
        v.ki0 = int'($urandom_range(0, 31));   v.ki1 = int'($urandom_range(0, 31));
      end
      v.e0 = 0; v.e1 = 0; v.hi = '0; v.lo = '0;
      run_sweep(v, -1, tag);
      check_outs(tag, m_out[0], m_out[1], m_hi, m_lo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
